// File: rtl/gated_nn_pkg.sv
// Shared encodings and constant helpers for the gated conv-datapath blocks.
package gated_nn_pkg;

    typedef enum logic {
        MODE_PASS = 1'b0,
        MODE_ACC  = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_level_gated.sv
// One registered adder-tree level: sign-extends and sums adjacent operand pairs,
// with clock-enable, synchronous clear of the valid bit and a mode pass-through.
module adder_level_gated #(
    parameter int PAIRS = 4,
    parameter int W     = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     in_mode,
    input  logic [2*PAIRS*W-1:0]     in_data,
    output logic                     out_valid,
    output logic                     out_mode,
    output logic [PAIRS*(W+1)-1:0]   out_data
);

    function automatic logic [W:0] sext(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    // NOTE: state registers use non-blocking assignments so every level samples
    // the previous level's value from before the edge, not the freshly updated one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_mode <= in_mode;
                // Sum registers only toggle on real data, bubbles leave them quiet.
                for (int p = 0; p < PAIRS; p++) begin
                    out_data[p*(W+1) +: W+1] <= sext(in_data[2*p*W +: W])
                                              + sext(in_data[(2*p+1)*W +: W]);
                end
            end
        end
    end

endmodule

// File: rtl/gated_adder_tree_acc.sv
// Gated NUM_IN-operand signed adder tree with optional ACC_LEN-sum accumulation
// and a global stall, feeding the activation/pooling stage.
module gated_adder_tree_acc
    import gated_nn_pkg::*;
#(
    parameter  int NUM_IN  = 8,
    parameter  int IN_W    = 14,
    parameter  int ACC_LEN = 4,
    localparam int L       = clog2(NUM_IN),
    localparam int TREE_W  = IN_W + L,
    localparam int OUT_W   = TREE_W + clog2(ACC_LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     mode,
    input  logic [NUM_IN-1:0]        lane_en,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     done,
    output logic                     busy
);

    localparam int CNT_W = (clog2(ACC_LEN) > 0) ? clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [IN_W-1:0]          op_q [NUM_IN];
    logic [NUM_IN-1:0]        lane_q;
    logic                     v0_q, m0_q;
    logic [NUM_IN*IN_W-1:0]   lvl0_bus;
    logic [L-1:0]             lvl_vld;
    logic signed [TREE_W-1:0] tree_sum;
    logic                     tree_vld, tree_mode;

    // Gated lanes keep their old operand; the mask stops it reaching the adders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            m0_q   <= 1'b0;
            lane_q <= '0;
            for (int i = 0; i < NUM_IN; i++) op_q[i] <= '0;
        end else if (clear) begin
            v0_q <= 1'b0;
        end else if (enable) begin
            v0_q <= in_valid;
            if (in_valid) begin
                m0_q   <= mode;
                lane_q <= lane_en;
                for (int i = 0; i < NUM_IN; i++)
                    if (lane_en[i]) op_q[i] <= in_data[i*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        lvl0_bus = '0;
        for (int i = 0; i < NUM_IN; i++)
            lvl0_bus[i*IN_W +: IN_W] = op_q[i] & {IN_W{lane_q[i]}};
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int W     = IN_W + k;
        localparam int PAIRS = NUM_IN >> (k + 1);
        logic [2*PAIRS*W-1:0]   din;
        logic [PAIRS*(W+1)-1:0] sum;
        logic                   vin, min, vld, md;

        if (k == 0) begin : g_first
            assign din = lvl0_bus;
            assign vin = v0_q;
            assign min = m0_q;
        end else begin : g_next
            assign din = g_lvl[k-1].sum;
            assign vin = g_lvl[k-1].vld;
            assign min = g_lvl[k-1].md;
        end

        adder_level_gated #(.PAIRS(PAIRS), .W(W)) u_level (
            .clk(clk), .rst_n(rst_n), .en(enable), .clear(clear),
            .in_valid(vin), .in_mode(min), .in_data(din),
            .out_valid(vld), .out_mode(md), .out_data(sum)
        );

        assign lvl_vld[k] = vld;
        if (k == L - 1) begin : g_last
            assign tree_sum  = sum;
            assign tree_vld  = vld;
            assign tree_mode = md;
        end
    end

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] acc_q, acc_d, res_d, sum_ext;
    logic                    ov_q, fire;

    assign sum_ext = OUT_W'(tree_sum);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = out_data;
        fire    = 1'b0;
        if (tree_vld) begin
            if (mode_e'(tree_mode) == MODE_PASS || ACC_LEN == 1) begin
                res_d   = sum_ext;
                fire    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                acc_d   = sum_ext;
                cnt_d   = CNT_W'(1);
                state_d = ACCUM;
            end else if (cnt_q == CNT_LAST) begin
                res_d   = acc_q + sum_ext;
                fire    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d = acc_q + sum_ext;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ov_q     <= 1'b0;
            out_data <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ov_q    <= 1'b0;
        end else if (enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ov_q     <= fire;
            out_data <= res_d;
        end
    end

    // A result held across a stall is shown once, in the first enabled cycle.
    assign out_valid = ov_q & enable & ~clear;
    assign done      = out_valid;
    assign busy      = v0_q | (|lvl_vld) | (state_q == ACCUM);

endmodule

// File: tb/tb_gated_adder_tree_acc.sv
// Scoreboard bench for gated_adder_tree_acc at NUM_IN=8, IN_W=14, ACC_LEN=4.
module tb_gated_adder_tree_acc;

    localparam int NUM_IN  = 8;
    localparam int IN_W    = 14;
    localparam int ACC_LEN = 4;
    localparam int OUT_W   = 19;
    localparam logic PASS  = 1'b0;
    localparam logic ACC   = 1'b1;

    logic                     clk, rst_n, enable, clear, in_valid, mode;
    logic [NUM_IN-1:0]        lane_en;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid, done, busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int cyc   = 0;
    logic signed [OUT_W-1:0] exp_q [$];
    int out_cyc_q [$];

    gated_adder_tree_acc #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_LEN(ACC_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .mode(mode), .lane_en(lane_en), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every out_valid pops one expected result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_out = n_out + 1;
            out_cyc_q.push_back(cyc);
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL sb_unexpected: got out_data=%0d, required no output", out_data);
            end else begin
                logic signed [OUT_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err = n_err + 1;
                    $display("FAIL sb_data: got %0d, required %0d", out_data, e);
                end
            end
            n_cmp = n_cmp + 1;
            if (done !== 1'b1) begin
                n_err = n_err + 1;
                $display("FAIL sb_done: got %b, required 1", done);
            end
        end
    end

    function automatic logic [NUM_IN*IN_W-1:0] vec_ramp(input int start);
        logic [NUM_IN*IN_W-1:0] v;
        for (int i = 0; i < NUM_IN; i++) v[i*IN_W +: IN_W] = IN_W'(start + i);
        return v;
    endfunction

    function automatic logic [NUM_IN*IN_W-1:0] vec_fill(input int val);
        logic [NUM_IN*IN_W-1:0] v;
        for (int i = 0; i < NUM_IN; i++) v[i*IN_W +: IN_W] = IN_W'(val);
        return v;
    endfunction

    function automatic logic [NUM_IN*IN_W-1:0] vec_lane0(input int val);
        logic [NUM_IN*IN_W-1:0] v;
        v = '0;
        v[IN_W-1:0] = IN_W'(val);
        return v;
    endfunction

    task automatic drive(input logic m, input logic [NUM_IN-1:0] le,
                         input logic [NUM_IN*IN_W-1:0] d);
        in_valid = 1'b1;
        mode     = m;
        lane_en  = le;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            idle(1);
            k++;
        end
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        idle(6);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        n_cmp = n_cmp + 1;
        if (got !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp = n_cmp + 1;
        if (out_data !== '0) begin
            n_err = n_err + 1;
            $display("FAIL reset_data: got %0d, required 0", out_data);
        end
        expect_bit("reset_valid", out_valid, 1'b0);
        expect_bit("reset_done", done, 1'b0);
        expect_bit("reset_busy", busy, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_pass;
        int lat;
        lat = -1;
        exp_q.push_back(OUT_W'(36));
        drive(PASS, 8'hFF, vec_ramp(1));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp = n_cmp + 1;
        if (lat != 4) begin
            n_err = n_err + 1;
            $display("FAIL pass_latency: got %0d cycles, required 4", lat);
        end
        expect_bit("pass_done", done, 1'b1);
        idle(3);
        expect_bit("pass_busy_after", busy, 1'b0);
        exp_q.push_back(OUT_W'(-65536));
        drive(PASS, 8'hFF, vec_fill(-8192));
        drain("pass_min");
    endtask

    task automatic test_acc_min;
        int base;
        base = n_out;
        exp_q.push_back(OUT_W'(-262144));
        for (int i = 0; i < ACC_LEN; i++) drive(ACC, 8'hFF, vec_fill(-8192));
        drain("acc_min");
        n_cmp = n_cmp + 1;
        if (n_out - base != 1) begin
            n_err = n_err + 1;
            $display("FAIL acc_min_pulses: got %0d, required 1", n_out - base);
        end
    endtask

    task automatic test_lane_mask;
        exp_q.push_back(OUT_W'(800));
        drive(PASS, 8'hFF, vec_fill(100));
        exp_q.push_back(OUT_W'(10));
        drive(PASS, 8'h0F, vec_ramp(1));
        drain("mask");
        for (int i = 0; i < NUM_IN; i++) begin
            logic [IN_W-1:0] req;
            req = (i < 4) ? IN_W'(i + 1) : IN_W'(100);
            n_cmp = n_cmp + 1;
            if (dut.op_q[i] !== req) begin
                n_err = n_err + 1;
                $display("FAIL mask_probe_lane%0d: got %0d, required %0d", i, dut.op_q[i], req);
            end
        end
    endtask

    task automatic test_acc_frame;
        int base;
        base = n_out;
        exp_q.push_back(OUT_W'(100));
        drive(ACC, 8'hFF, vec_lane0(10));
        drive(ACC, 8'hFF, vec_lane0(20));
        drive(ACC, 8'hFF, vec_lane0(30));
        drive(ACC, 8'hFF, vec_lane0(40));
        drain("acc_frame");
        n_cmp = n_cmp + 1;
        if (n_out - base != 1) begin
            n_err = n_err + 1;
            $display("FAIL acc_frame_pulses: got %0d, required 1", n_out - base);
        end
        // Pass vector mid-frame: partial 10+20 is dropped, the next frame starts fresh.
        exp_q.push_back(OUT_W'(5));
        exp_q.push_back(OUT_W'(10));
        drive(ACC, 8'hFF, vec_lane0(10));
        drive(ACC, 8'hFF, vec_lane0(20));
        drive(PASS, 8'hFF, vec_lane0(5));
        for (int i = 1; i <= 4; i++) drive(ACC, 8'hFF, vec_lane0(i));
        drain("acc_insert");
    endtask

    task automatic test_stall;
        int accept;
        out_cyc_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back(OUT_W'(i));
        drive(PASS, 8'hFF, vec_lane0(1));
        accept = cyc;
        for (int i = 2; i <= 4; i++) drive(PASS, 8'hFF, vec_lane0(i));
        idle(1);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = vec_lane0(99);
        #1;
        expect_bit("stall_valid_1", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_bit("stall_valid_2", out_valid, 1'b0);
        @(posedge clk); #1;
        enable = 1'b1;
        drain("stall");
        n_cmp = n_cmp + 1;
        if (out_cyc_q.size() == 0 || out_cyc_q[0] - accept != 6) begin
            n_err = n_err + 1;
            $display("FAIL stall_latency: got %0d, required 6",
                     (out_cyc_q.size() == 0) ? -1 : out_cyc_q[0] - accept);
        end
    endtask

    task automatic test_clear_reset;
        drive(ACC, 8'hFF, vec_fill(1));
        drive(ACC, 8'hFF, vec_fill(1));
        idle(6);
        expect_bit("clear_busy_before", busy, 1'b1);
        clear = 1'b1;
        #1;
        expect_bit("clear_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        expect_bit("clear_busy_after", busy, 1'b0);
        drive(ACC, 8'hFF, vec_fill(1));
        idle(1);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if (out_data !== '0) begin
            n_err = n_err + 1;
            $display("FAIL rst_data: got %0d, required 0", out_data);
        end
        expect_bit("rst_busy", busy, 1'b0);
        expect_bit("rst_valid", out_valid, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back(OUT_W'(32));
        for (int i = 0; i < ACC_LEN; i++) drive(ACC, 8'hFF, vec_fill(1));
        drain("after_rst");
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        lane_en  = '0;
        in_data  = '0;
        test_reset();
        test_pass();
        test_acc_min();
        test_lane_mask();
        test_acc_frame();
        test_stall();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gated_adder_tree_acc.md
Name: gated_adder_tree_acc

Overview:
- Parametrised successor to the fixed-width, single-pair gated adder stages in the convolution datapath.
- Reduces NUM_IN signed operands through a registered binary adder tree with per-lane operand gating and a global enable/stall.
- Optionally accumulates ACC_LEN tree sums per output, e.g. for channel accumulation.
- Sits between the multiplier array and the activation/pooling stage of any conv layer.

Parameters:
- NUM_IN, 8: operand count; a power of two, at least 2. Tree depth L = log2(NUM_IN).
- IN_W, 14: signed operand width.
- ACC_LEN, 4: tree sums per output in accumulate mode; at least 1.
- Derived (localparam, not overridable): TREE_W = IN_W + L; OUT_W = TREE_W + clog2(ACC_LEN).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: global gate. When low, the whole block stalls.
- clear, input, 1: synchronous flush.
- in_valid, input, 1: operand vector valid this cycle.
- mode, input, 1: 0 = MODE_PASS, 1 = MODE_ACC. Sampled with in_valid.
- lane_en, input, NUM_IN: per-lane operand gate. Bit i gates operand i.
- in_data, input, NUM_IN*IN_W: packed operands. Lane i occupies bits [i*IN_W +: IN_W].
- out_data, output, OUT_W: signed result.
- out_valid, output, 1: out_data valid, one-cycle pulse.
- done, output, 1: frame complete, one-cycle pulse.
- busy, output, 1: data is in flight or a partial frame is held.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, valid bits, counter and accumulator go to 0; out_data=0, out_valid=0, done=0, busy=0.
- Arithmetic:
  - Two's complement throughout.
  - Each tree level sign-extends by 1 bit before adding, so the tree cannot overflow.
  - Accumulator is OUT_W wide, which is exact for ACC_LEN sums.
  - Pass-mode output is the tree sum sign-extended to OUT_W.
- Lane gating:
  - Lane i contributes 0 when lane_en[i]=0.
  - Its level-0 operand register does not load; it holds its previous value (operand isolation), and an AND-mask forces 0 into the adder.
  - lane_en is sampled with in_valid.
- Pipeline:
  - Level 0 captures operands.
  - L adder levels, each registered.
  - One accumulator/output register.
  - Latency: out_valid rises L+1 cycles after the accepted in_valid (4 cycles for NUM_IN=8).
  - Throughput: one vector per cycle.
  - mode and the valid bit travel down the pipe with the data.
- Stall (enable=0):
  - All registers hold, including valid bits, counter and accumulator.
  - out_valid=0 and done=0 while stalled; out_data holds.
  - in_valid during the stall is dropped, not queued.
  - On re-enable, the pipeline resumes with contents intact.
- Priority: rst_n > clear > enable.
- clear=1: all valid bits, counter and accumulator go to 0 on the next edge; out_valid=done=0 that cycle; the in-flight data is discarded.
- Output FSM, states IDLE and ACCUM, counter cnt of width clog2(ACC_LEN):
  - MODE_PASS sum arriving: out_data=sum, out_valid=1, done=1. If the FSM was in ACCUM, the partial frame is discarded, cnt=0, state goes to IDLE.
  - MODE_ACC sum in IDLE:
    - If ACC_LEN=1, output directly as in pass mode.
    - Otherwise acc=sum, cnt=1, go to ACCUM.
  - MODE_ACC sum in ACCUM with cnt<ACC_LEN-1: acc=acc+sum, cnt increments.
  - MODE_ACC sum in ACCUM with cnt==ACC_LEN-1: out_data=acc+sum, out_valid=1, done=1, cnt=0, go to IDLE.
  - No sum arriving (bubble): hold state and counter.
- busy = (any pipeline valid bit) OR (state==ACCUM).

Decomposition:
- Shared package/header gated_nn_pkg: MODE_PASS/MODE_ACC encodings, FSM state encodings IDLE/ACCUM, a clog2 constant function.
- Sub-module adder_level_gated(PAIRS, W):
  - One registered tree level.
  - Sign-extends and adds adjacent pairs; has clock-enable, clear and valid pass-through.
  - Instantiated L times in a generate loop.
- Lane mask, accumulator and FSM stay in the top module.

Test Plan (NUM_IN=8, IN_W=14, ACC_LEN=4):
- MODE_PASS, lanes 1..8, all lanes enabled -> out_data=36 and out_valid=done=1 exactly 4 cycles after in_valid; busy=0 afterwards.
- MODE_PASS, all lanes -8192 -> -65536. Then MODE_ACC with four such vectors back to back -> one output of -262144 (OUT_W=19 minimum), done pulses once.
- lane_en=8'b00001111 with lanes 1..8 -> 10; masked lanes' level-0 registers are unchanged (probe).
- MODE_ACC with sums 10, 20, 30, 40 back to back -> out_valid only on the 4th, out_data=100. A pass-mode vector inserted after the 2nd -> its own sum is output and the partial 30 is discarded.
- enable low for 2 cycles mid-stream with one in_valid during the stall -> outputs delayed by 2 cycles with values intact; the stalled vector never appears; out_valid=0 while enable is low.
- clear asserted mid-frame (cnt=2), then rst_n pulsed asynchronously mid-stream -> outputs 0 immediately; the next 4-vector frame of 1s per lane (sum 8 each) gives 32.
